// File: rtl/png_crc32_chk_if.sv
// Chunk-data, stored-CRC and result signals of the PNG chunk CRC checker.
interface png_crc32_chk_if;
  logic        start_i;
  logic        val_i;
  logic [31:0] dat_i;
  logic        lst_i;
  logic [1:0]  byt_i;
  logic        rdy_o;
  logic        crc_val_i;
  logic [31:0] crc_i;
  logic        done_o;
  logic        ok_o;
  logic [31:0] crc_o;

  modport master (
    output start_i, val_i, dat_i, lst_i, byt_i, crc_val_i, crc_i,
    input  rdy_o, done_o, ok_o, crc_o
  );

  modport slave (
    input  start_i, val_i, dat_i, lst_i, byt_i, crc_val_i, crc_i,
    output rdy_o, done_o, ok_o, crc_o
  );
endinterface

// File: rtl/png_crc32_chk.sv
// PNG chunk CRC-32 checker: folds one byte per cycle, takes a word only in ACTV,
// then compares the final CRC with the stored field and pulses done_o.
module png_crc32_chk (
  input  logic            clk,
  input  logic            rst,
  png_crc32_chk_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ACTV, B1, B2, B3, WCRC, CMP} state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] res_q, res_d;
  logic        ok_q, ok_d;
  logic [23:0] dat_q, dat_d;
  logic        lst_q, lst_d;
  logic [1:0]  byt_q, byt_d;
  logic [7:0]  fold_byte;
  logic [31:0] crc_next;

  // Reflected CRC-32 over one byte, LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    fold_byte = bus.dat_i[31:24];
    case (state_q)
      B1:      fold_byte = dat_q[23:16];
      B2:      fold_byte = dat_q[15:8];
      B3:      fold_byte = dat_q[7:0];
      default: fold_byte = bus.dat_i[31:24];
    endcase
    crc_next = crc_step(crc_q, fold_byte);
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    res_d   = res_q;
    ok_d    = ok_q;
    dat_d   = dat_q;
    lst_d   = lst_q;
    byt_d   = byt_q;
    case (state_q)
      IDLE: ;
      ACTV: begin
        if (bus.val_i) begin
          crc_d   = crc_next;
          dat_d   = bus.dat_i[23:0];
          lst_d   = bus.lst_i;
          byt_d   = bus.byt_i;
          state_d = (bus.lst_i && bus.byt_i == 2'd1) ? WCRC : B1;
        end
      end
      B1: begin
        crc_d   = crc_next;
        state_d = (lst_q && byt_q == 2'd2) ? WCRC : B2;
      end
      B2: begin
        crc_d   = crc_next;
        state_d = (lst_q && byt_q == 2'd3) ? WCRC : B3;
      end
      B3: begin
        crc_d   = crc_next;
        state_d = lst_q ? WCRC : ACTV;
      end
      WCRC: begin
        if (bus.crc_val_i) begin
          res_d   = ~crc_q;
          ok_d    = (~crc_q == bus.crc_i);
          state_d = CMP;
        end
      end
      CMP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A new start wins over everything, including a word offered in the same cycle.
    if (bus.start_i) begin
      state_d = ACTV;
      crc_d   = 32'hFFFFFFFF;
      ok_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= 32'd0;
      res_q   <= 32'd0;
      ok_q    <= 1'b0;
      dat_q   <= 24'd0;
      lst_q   <= 1'b0;
      byt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      res_q   <= res_d;
      ok_q    <= ok_d;
      dat_q   <= dat_d;
      lst_q   <= lst_d;
      byt_q   <= byt_d;
    end
  end

  assign bus.rdy_o  = (state_q == ACTV) && !bus.start_i;
  assign bus.done_o = (state_q == CMP);
  assign bus.ok_o   = ok_q;
  assign bus.crc_o  = res_q;

endmodule

// File: doc/png_crc32_chk.md
PNG_CRC32_CHK -- requirements
Module: png_crc32_chk

Interface
REQ-001 SHALL have no parameters; byte order, polynomial and widths are fixed.
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start_i  in  1  begin a new chunk check; initialise CRC.
REQ-005 SHALL have port: val_i  in  1  dat_i word valid.
REQ-006 SHALL have port: dat_i  in  32  chunk type/data word, first stream byte in [31:24].
REQ-007 SHALL have port: lst_i  in  1  qualifies val_i: final data word of the chunk.
REQ-008 SHALL have port: byt_i  in  2  valid bytes in the last word (0 means 4, 1..3 means that many from [31:24] down); ignored when lst_i=0.
REQ-009 SHALL have port: rdy_o  out  1  word accepted this cycle when rdy_o and val_i are both high.
REQ-010 SHALL have port: crc_val_i  in  1  stored chunk CRC present on crc_i.
REQ-011 SHALL have port: crc_i  in  32  CRC field read from the PNG stream, big-endian value.
REQ-012 SHALL have port: done_o  out  1  one-cycle pulse: check complete.
REQ-013 SHALL have port: ok_o  out  1  computed CRC equals crc_i; valid from done_o until next start_i.
REQ-014 SHALL have port: crc_o  out  32  computed CRC; valid from done_o until next start_i.

Function
REQ-015 SHALL compute the PNG/IEEE CRC-32: reflected poly 0xEDB88320 (normal form 0x04C11DB7), init 0xFFFFFFFF, final XOR 0xFFFFFFFF, bytes LSB-first, one byte per cycle.
REQ-016 SHALL implement the FSM IDLE, ACTV, B1, B2, B3, WCRC, CMP.
REQ-017 IDLE: start_i -> ACTV and CRC register <= 0xFFFFFFFF; otherwise stay in IDLE.
REQ-018 ACTV: rdy_o=1; on val_i, latch dat_i and fold byte [31:24] into the CRC in the same cycle.
REQ-019 ACTV transitions on val_i: to B1 if lst_i=0, or if lst_i=1 and byt_i is in {0,2,3}; to WCRC if lst_i=1 and byt_i=1; without val_i, stay in ACTV.
REQ-020 B1/B2/B3 SHALL fold latched bytes [23:16]/[15:8]/[7:0] respectively; rdy_o=0.
REQ-021 From B1/B2/B3 SHALL go to the next byte state, or to ACTV after B3 for a non-last word, or to WCRC as soon as the last valid byte of a last word is folded (byt_i=2 after B1, 3 after B2, 0 after B3).
REQ-022 Throughput SHALL be one full word per 4 cycles; a word SHALL never be accepted outside ACTV.
REQ-023 WCRC: on crc_val_i, register crc_o <= final CRC and ok_o <= (final CRC == crc_i), then go to CMP; otherwise wait indefinitely.
REQ-024 CMP: done_o=1 for exactly this cycle, then go to IDLE; ok_o/crc_o hold.
REQ-025 start_i in any non-IDLE state SHALL abort the current chunk: CRC <= 0xFFFFFFFF, go to ACTV; any val_i in that same cycle SHALL be ignored.
REQ-026 SHALL ignore val_i outside ACTV, crc_val_i outside WCRC, and byt_i when lst_i=0.
REQ-027 start_i SHALL clear ok_o to 0; crc_o SHALL hold until the next CMP update.

Reset
REQ-028 rst=1 SHALL force IDLE immediately, independent of clk.
REQ-029 Reset values: CRC register 0, rdy_o=0, done_o=0, ok_o=0, crc_o=0x00000000; a reset mid-chunk SHALL discard all partial state.

Verification
REQ-030 "IEND": start, then one word 0x49454E44 with lst=1, byt=0, then crc_i=0xAE426082 -> crc_o=0xAE426082, ok_o=1, done_o pulses once, 4 cycles after acceptance plus 1 cycle after crc_val_i.
REQ-031 "123456789": words 0x31323334, 0x35363738, then 0x39xxxxxx with lst=1, byt=1; crc_i=0xCBF43926 -> ok_o=1; rdy_o low for 3 cycles after each full word; WCRC entered the cycle after the last word.
REQ-032 Mismatch: repeat the IEND case with crc_i=0xAE426083 -> crc_o=0xAE426082, ok_o=0, done_o pulses once.
REQ-033 Backpressure/idle: hold val_i high continuously -> exactly one word is accepted per 4 cycles; gaps in val_i and delayed crc_val_i (10 cycles) leave the result unchanged.
REQ-034 Abort: start_i during B2 of the first chunk, then run the IEND case -> crc_o=0xAE426082, ok_o=1; rst asserted in B1 -> rdy_o=0 and all outputs at reset values asynchronously.
